// File: rtl/or2_event_capture.sv
// Debounced capture of A1|A2 with a saturating pending-event counter and REQ/ACK pop.
// Define OR2_EVCAP_BOTH_EDGE_EN to count falling Z transitions as events too.
module or2_event_capture #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYC    = 4,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             A1,
    input  logic             A2,
    input  logic             ACK,
    output logic             Z,
    output logic             REQ,
    output logic [CNT_W-1:0] CNT,
    output logic             OVF
);

    typedef enum logic [1:0] {StLo, StRise, StHi, StFall} state_e;

    localparam logic [3:0]       FiltCyc = 4'(FILT_CYC);
    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q, state_d;
    logic [3:0]             fc_q, fc_d;
    logic [3:0]             fc_inc;
    logic                   z_q, z_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   rise_ev;
    logic                   ev;
    logic                   pop;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], A1 | A2};
        end
    end

    assign s      = sync_q[SYNC_STAGES-1];
    assign fc_inc = fc_q + 4'd1;

    // fc counts consecutive samples that disagree with the current level.
    always_comb begin
        state_d = state_q;
        fc_d    = fc_q;
        case (state_q)
            StLo: begin
                if (s) begin
                    if (FiltCyc == 4'd1) begin
                        state_d = StHi;
                        fc_d    = 4'd0;
                    end else begin
                        state_d = StRise;
                        fc_d    = 4'd1;
                    end
                end else begin
                    fc_d = 4'd0;
                end
            end
            StRise: begin
                if (s) begin
                    if (fc_inc == FiltCyc) begin
                        state_d = StHi;
                        fc_d    = 4'd0;
                    end else begin
                        fc_d = fc_inc;
                    end
                end else begin
                    state_d = StLo;
                    fc_d    = 4'd0;
                end
            end
            StHi: begin
                if (!s) begin
                    if (FiltCyc == 4'd1) begin
                        state_d = StLo;
                        fc_d    = 4'd0;
                    end else begin
                        state_d = StFall;
                        fc_d    = 4'd1;
                    end
                end else begin
                    fc_d = 4'd0;
                end
            end
            StFall: begin
                if (!s) begin
                    if (fc_inc == FiltCyc) begin
                        state_d = StLo;
                        fc_d    = 4'd0;
                    end else begin
                        fc_d = fc_inc;
                    end
                end else begin
                    state_d = StHi;
                    fc_d    = 4'd0;
                end
            end
            default: begin
                state_d = StLo;
                fc_d    = 4'd0;
            end
        endcase
    end

    assign z_d     = (state_d == StHi) || (state_d == StFall);
    assign rise_ev = ((state_q == StLo) || (state_q == StRise)) && (state_d == StHi);

`ifdef OR2_EVCAP_BOTH_EDGE_EN
    logic fall_ev;
    assign fall_ev = ((state_q == StHi) || (state_q == StFall)) && (state_d == StLo);
    assign ev      = rise_ev | fall_ev;
`else
    assign ev      = rise_ev;
`endif

    assign pop = ACK & REQ;

    // Simultaneous event and pop cancel; the pop still clears OVF.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (ev && !pop) begin
            if (cnt_q == CntMax) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntOne;
            end
        end else if (pop && !ev) begin
            cnt_d = cnt_q - CntOne;
            ovf_d = 1'b0;
        end else if (pop) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StLo;
            fc_q    <= 4'd0;
            z_q     <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fc_q    <= fc_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Z   = z_q;
    assign CNT = cnt_q;
    assign REQ = (cnt_q != '0);
    assign OVF = ovf_q;

endmodule
